// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHR  = 3'd2,
    SHL  = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6,
    RSVD = 3'd7
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } burst_state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational next-value function of the shift register for one operation.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  shift_mode_t      mode_i,
  input  logic             ser_in_i,
  input  logic [WIDTH-1:0] par_in_i,
  output logic [WIDTH-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      LOAD:    q_next_o = par_in_i;
      SHR:     q_next_o = {ser_in_i, q_i[WIDTH-1:1]};
      SHL:     q_next_o = {q_i[WIDTH-2:0], ser_in_i};
      ROR:     q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      ROL:     q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      ASR:     q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default: q_next_o = q_i;  // HOLD and the reserved code
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with step mode and a counted burst FSM (IDLE/BURST/DONE).
// Optional even-parity output enabled by defining PARITY_EN.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  burst_state_t     state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  shift_mode_t      mode_lat_q, mode_lat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] step_val;
  shift_mode_t      step_mode;

  // During a burst the latched operation drives the step unit; otherwise the live mode.
  assign step_mode = (state_q == BURST) ? mode_lat_q : shift_mode_t'(mode);

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .q_i     (shreg_q),
    .mode_i  (step_mode),
    .ser_in_i(ser_in),
    .par_in_i(par_in),
    .q_next_o(step_val)
  );

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mode_lat_q <= HOLD;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_lat_q <= mode_lat_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_lat_d = mode_lat_q;
    shreg_d    = shreg_q;
    case (state_q)
      IDLE: begin
        // start wins over en; the accepting edge leaves q untouched
        if (start) begin
          mode_lat_d = shift_mode_t'(mode);
          count_d    = amount;
          state_d    = BURST;
        end else if (en) begin
          shreg_d = step_val;
        end
      end
      BURST: begin
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          shreg_d = step_val;
          count_d = count_q - AMT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign q           = shreg_q;
  assign ser_out_lsb = shreg_q[0];
  assign ser_out_msb = shreg_q[WIDTH-1];
  assign busy        = (state_q == BURST);
  assign done        = (state_q == DONE);

`ifdef PARITY_EN
  assign parity = ^shreg_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;
  localparam int END_OP  = 8;  // burst step that only notices count exhausted
  localparam int DONE_OP = 9;  // the done cycle

  logic          clk_2 = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic          en;
  logic          start;
  logic [AW-1:0] amount;
  logic          ser_in;
  logic [W-1:0]  par_in;
  logic [W-1:0]  q;
  logic          ser_out_lsb;
  logic          ser_out_msb;
  logic          busy;
  logic          done;
  logic          parity;

  int checks   = 0;
  int failures = 0;

  // Model: register value plus a queue of the edges still owed by an accepted burst.
  int m_q;
  int plan[$];
  int seen_q[$];

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .mode       (mode),
    .en         (en),
    .start      (start),
    .amount     (amount),
    .ser_in     (ser_in),
    .par_in     (par_in),
    .q          (q),
    .ser_out_lsb(ser_out_lsb),
    .ser_out_msb(ser_out_msb),
    .busy       (busy),
    .done       (done),
    .parity     (parity)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int apply_op(int qv, int op, int s, int p);
    case (op)
      1:       return p & MASK;
      2:       return (qv >> 1) | (s << (W - 1));
      3:       return ((qv << 1) | s) & MASK;
      4:       return (qv >> 1) | ((qv & 1) << (W - 1));
      5:       return ((qv << 1) | (qv >> (W - 1))) & MASK;
      6:       return (qv >> 1) | (qv & (1 << (W - 1)));
      default: return qv;
    endcase
  endfunction

  function automatic void model_edge();
    int op;
    if (plan.size() == 0) begin
      if (start) begin
        for (int i = 0; i < int'(amount); i++) plan.push_back(int'(mode));
        plan.push_back(END_OP);
        plan.push_back(DONE_OP);
      end else if (en) begin
        m_q = apply_op(m_q, int'(mode), int'(ser_in), int'(par_in));
      end
    end else begin
      op = plan.pop_front();
      if (op < END_OP) m_q = apply_op(m_q, op, int'(ser_in), int'(par_in));
    end
  endfunction

  function automatic void model_reset();
    plan.delete();
    m_q = 0;
  endfunction

  task automatic compare_all();
    int eb, ed, ep;
    eb = (plan.size() > 0 && plan[0] != DONE_OP) ? 1 : 0;
    ed = (plan.size() > 0 && plan[0] == DONE_OP) ? 1 : 0;
`ifdef PARITY_EN
    ep = $countones(m_q) & 1;
`else
    ep = 0;
`endif
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(eb));
    check("done", 32'(done), 32'(ed));
    check("ser_out_lsb", 32'(ser_out_lsb), 32'(m_q & 1));
    check("ser_out_msb", 32'(ser_out_msb), 32'((m_q >> (W - 1)) & 1));
    check("parity", 32'(parity), 32'(ep));
  endtask

  task automatic tick();
    @(posedge clk_2);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_2);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic step_op(input logic [2:0] md, input logic s, input logic [W-1:0] p);
    en = 1'b1; start = 1'b0; mode = md; ser_in = s; par_in = p;
    tick();
    en = 1'b0;
  endtask

  // Accept a burst, optionally hammer live inputs while busy, and return busy/done cycle counts.
  task automatic run_burst(input logic [2:0] md, input int amt, input bit noisy,
                           output int bc, output int dc);
    en = 1'b0; start = 1'b1; mode = md; amount = AW'(amt);
    tick();
    bc = int'(busy);
    dc = 0;
    seen_q.delete();
    for (int i = 0; i < 40; i++) begin
      start = noisy;
      en    = noisy;
      if (noisy) mode = 3'($urandom);
      tick();
      seen_q.push_back(int'(q));
      bc += int'(busy);
      dc += int'(done);
      if (done) break;
    end
    start = 1'b0; en = 1'b0;
    tick();
  endtask

  int bc, dc, ep;
  logic [W-1:0] shr_exp [4];

  initial begin
    reset = 1'b1; mode = 3'd0; en = 1'b0; start = 1'b0; amount = '0;
    ser_in = 1'b0; par_in = '0;
    do_reset();

    // Load then hold
    step_op(3'd1, 1'b0, 8'hA5);
    check("load_a5", 32'(q), 32'hA5);
    for (int i = 0; i < 3; i++) step_op(3'd0, 1'b1, 8'h3C);
    check("hold_a5", 32'(q), 32'hA5);

    // Shift right with ser_in=1 from zero
    step_op(3'd1, 1'b0, 8'h00);
    shr_exp[0] = 8'h80; shr_exp[1] = 8'hC0; shr_exp[2] = 8'hE0; shr_exp[3] = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      step_op(3'd2, 1'b1, 8'h55);
      check("shr_q", 32'(q), 32'(shr_exp[i]));
      check("shr_lsb", 32'(ser_out_lsb), 32'd0);
    end

    // ROL burst of 3 with start/en/mode noise while busy
    step_op(3'd1, 1'b0, 8'h81);
    run_burst(3'd5, 3, 1'b1, bc, dc);
    check("rol_busy_cycles", 32'(bc), 32'd4);
    check("rol_done_pulses", 32'(dc), 32'd1);
    check("rol_step1", 32'(seen_q[0]), 32'h03);
    check("rol_step2", 32'(seen_q[1]), 32'h06);
    check("rol_step3", 32'(seen_q[2]), 32'h0C);
    check("rol_final", 32'(q), 32'h0C);

    // ASR burst of 2 from 0x80, then a zero-length burst
    step_op(3'd1, 1'b0, 8'h80);
    run_burst(3'd6, 2, 1'b0, bc, dc);
    check("asr_final", 32'(q), 32'hE0);
    check("asr_done_pulses", 32'(dc), 32'd1);
    run_burst(3'd2, 0, 1'b0, bc, dc);
    check("amt0_busy_cycles", 32'(bc), 32'd1);
    check("amt0_done_pulses", 32'(dc), 32'd1);
    check("amt0_q", 32'(q), 32'hE0);

    // Saturating shift with amount > WIDTH
    step_op(3'd1, 1'b0, 8'h5A);
    ser_in = 1'b1;
    run_burst(3'd3, 10, 1'b0, bc, dc);
    check("shl_sat", 32'(q), 32'hFF);

    // Reset in the middle of a burst: no done pulse afterwards
    step_op(3'd1, 1'b0, 8'h3C);
    en = 1'b0; start = 1'b1; mode = 3'd3; amount = AW'(5); ser_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_burst_busy", 32'(busy), 32'd1);
    do_reset();
    check("reset_q", 32'(q), 32'h00);
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dc += int'(done);
    end
    check("reset_no_done", 32'(dc), 32'd0);

    // Parity
`ifdef PARITY_EN
    ep = 1;
`else
    ep = 0;
`endif
    step_op(3'd1, 1'b0, 8'h07);
    check("parity_07", 32'(parity), 32'(ep));
    step_op(3'd1, 1'b0, 8'h0F);
    check("parity_0f", 32'(parity), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom % 6) == 0;
      en     = ($urandom % 2) == 0;
      mode   = 3'($urandom);
      amount = AW'($urandom_range(0, 12));
      ser_in = 1'($urandom);
      par_in = W'($urandom);
      if (($urandom % 150) == 0) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register for the lab FPGA board; successor of the 4-bit serial/parallel register.
- Generalised width; seven operating modes: hold, load, shift right/left, rotate right/left, arithmetic shift right.
- Two ways to operate:
  - Step mode: one operation per enabled clock.
  - Burst mode: a start handshake runs the latched operation N times automatically, with busy/done status for the board LEDs.
- Sits between SWI decoding in top and LED/SEG outputs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, $clog2(WIDTH+1), width of burst amount field (derived; not overridden).

Ports:
- clk_2  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- mode  input  3  operation select (encoding below).
- en  input  1  step-mode enable; ignored unless FSM is IDLE.
- start  input  1  burst request; sampled only in IDLE.
- amount  input  AMT_W  burst repeat count, latched on accepted start.
- ser_in  input  1  serial input bit for SHR (enters MSB) and SHL (enters LSB).
- par_in  input  WIDTH  parallel load value.
- q  output  WIDTH  register contents.
- ser_out_lsb  output  1  q[0], combinational.
- ser_out_msb  output  1  q[WIDTH-1], combinational.
- busy  output  1  high while FSM in BURST.
- done  output  1  one-cycle pulse, FSM in DONE.
- parity  output  1  see Optional Feature.

Behaviour:
- Reset (async): q=0, FSM=IDLE, count=0, latched mode=HOLD; busy=0, done=0. Reset mid-burst aborts immediately; no done pulse.
- Mode encoding, one operation = one clock edge:
  - 0 HOLD: q unchanged.
  - 1 LOAD: q=par_in.
  - 2 SHR: q={ser_in,q[W-1:1]}.
  - 3 SHL: q={q[W-2:0],ser_in}.
  - 4 ROR: q={q[0],q[W-1:1]}.
  - 5 ROL: q={q[W-2:0],q[W-1]}.
  - 6 ASR: q={q[W-1],q[W-1:1]}.
  - 7: reserved, behaves as HOLD.
- FSM states IDLE, BURST, DONE.
- IDLE:
  - start=1 has priority over en. Latch mode and amount; q unchanged this edge; go to BURST.
  - Else if en=1, apply mode to q at this edge (latency 1 clock).
  - Else hold.
- BURST:
  - If count==0, go to DONE with q unchanged.
  - Else apply latched mode, count-=1.
  - Live mode, en and start are ignored. ser_in and par_in are sampled live on each burst edge.
- DONE: done=1 for exactly one cycle; start/en ignored; next state IDLE.
- Timing: start accepted at edge t with amount k gives shifts at edges t+1..t+k, busy high k+1 cycles, done high in the cycle after edge t+k+1.
  - amount=0: busy 1 cycle, done, q unchanged.
- amount > WIDTH is legal. Rotates wrap naturally; shifts saturate to fill value.
- All q updates are synchronous except reset. No combinational path from inputs to q.

Optional Feature:
- Macro PARITY_EN.
- Defined: parity = ^q (even-parity bit, combinational from registered q).
- Undefined: parity tied to 0; no XOR tree synthesised.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [2:0] shift_mode_t {HOLD, LOAD, SHR, SHL, ROR, ROL, ASR, RSVD}.
  - typedef enum logic [1:0] burst_state_t {IDLE, BURST, DONE}.
- One sub-module, shift_step_unit: purely combinational next-value function (q, mode, ser_in, par_in -> q_next), parametrised by WIDTH.
- Top of block holds the FSM, count register and q register.

Test Plan:
- Reset asserted while in BURST (amount=5, after 2 shifts) -> q=0x00, busy=0, done never pulses; FSM IDLE next cycle.
- en=1, mode=LOAD, par_in=0xA5 for one edge -> q=0xA5 next cycle; then mode=HOLD, en=1 for 3 edges -> q stays 0xA5.
- q=0x00, en=1, mode=SHR, ser_in=1 for 4 edges -> q=0x80, 0xC0, 0xE0, 0xF0; ser_out_lsb=0 throughout.
- q=0x81, start=1, mode=ROL, amount=3 -> busy high 4 cycles, q=0x03,0x06,0x0C, done pulses once, final q=0x0C; start pulses during busy ignored.
- q=0x80, burst ASR amount=2 -> q=0xE0. Then burst amount=0 -> busy 1 cycle, done 1 cycle, q=0xE0.
- PARITY_EN defined, q=0x07 -> parity=1; q=0x0F -> parity=0. Undefined -> parity=0 always.
